// File: rtl/la_muxarb4_if.sv
// la_muxarb4_if: requester/arbiter bundle for la_muxarb4.
// The lock signal exists only when LA_MUXARB4_LOCK_EN is defined.
interface la_muxarb4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       active;
`ifdef LA_MUXARB4_LOCK_EN
    logic       lock;
    modport master(output req, done, lock, input gnt, s0, s1, active);
    modport slave(input req, done, lock, output gnt, s0, s1, active);
`else
    modport master(output req, done, input gnt, s0, s1, active);
    modport slave(input req, done, output gnt, s0, s1, active);
`endif
endinterface

// File: rtl/la_muxarb4.sv
// la_muxarb4: 4-way round-robin arbiter owning the select lines of a shared 4:1 mux.
// Define LA_MUXARB4_LOCK_EN to add a lock input that pins the current grant.
module la_muxarb4 #(
    parameter string PROP    = "DEFAULT",
    parameter int    HOLDMAX = 16,
    parameter int    GAP     = 1
) (
    input logic         clk,
    input logic         nreset,
    la_muxarb4_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam int CW = HOLDMAX > 2 ? $clog2(HOLDMAX) : 1;
    localparam logic [CW-1:0] CMAX = CW'(HOLDMAX == 0 ? 0 : HOLDMAX - 1);

    logic [1:0]    state_q, state_d, sel_q, sel_d, ptr_q, ptr_d, arb_ptr, win;
    logic [3:0]    gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock, in_grant, hold, others, timeout, rel, take;

`ifdef LA_MUXARB4_LOCK_EN
    assign lock = bus.lock;
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        in_grant = state_q == ST_GRANT;
        others   = |(bus.req & ~gnt_q);
        timeout  = HOLDMAX != 0 && cnt_q == CMAX && others;
        rel      = in_grant && (!bus.req[sel_q] || (!lock && (bus.done || timeout)));
        hold     = in_grant && !rel;
        // on release the just-served owner moves to lowest priority
        arb_ptr  = in_grant ? sel_q + 2'd1 : ptr_q;
        win      = arb_ptr;
        for (int i = 3; i >= 0; i--)
            if (bus.req[arb_ptr + 2'(i)]) win = arb_ptr + 2'(i);
        take     = |bus.req && (!in_grant || (rel && GAP == 0));
        state_d  = (take || hold) ? ST_GRANT : (rel && GAP != 0) ? ST_GAP : ST_IDLE;
        gnt_d    = take ? 4'(1) << win : hold ? gnt_q : 4'b0;
        sel_d    = take ? win : sel_q;
        ptr_d    = rel ? sel_q + 2'd1 : ptr_q;
        cnt_d    = !hold ? '0 : (HOLDMAX == 0 || cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.s0     = sel_q[0];
    assign bus.s1     = sel_q[1];
    assign bus.active = |gnt_q;
endmodule
